// File: rtl/ber_window_counter.sv
// Windowed bit-error counter: XOR compare, registered popcount tree and
// saturating accumulator under an IDLE/RUN/DRAIN measurement controller.
module ber_window_counter #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned WIN_W  = 24
) (
    input  logic              clk,
    input  logic              rs,
    input  logic              start,
    input  logic              stop,
    input  logic [WIN_W-1:0]  window_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic [DATA_W-1:0] in_data_2,
    input  logic              err_inject,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_count,
    output logic [WIN_W-1:0]  word_count,
    output logic              saturated
);

    localparam int unsigned LVL = $clog2(DATA_W);
    localparam int unsigned PW  = 1 << LVL;
    localparam int unsigned PCW = LVL + 1;
    localparam int unsigned D   = LVL + 1;
    localparam int unsigned DCW = $clog2(D + 1);
    localparam int unsigned AW  = ((CNT_W > PCW) ? CNT_W : PCW) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    logic [WIN_W-1:0]  win_len_q;
    logic [DCW-1:0]    drain_cnt;

    logic              accept_c;
    logic              start_c;
    logic              win_end_c;
    logic [DATA_W-1:0] diff_c;
    logic [PCW-1:0]    pop_c;
    logic              pop_vld_c;
    logic [AW-1:0]     acc_sum_c;
    logic              ovf_c;

    assign accept_c  = (state == RUN) && in_valid;
    assign start_c   = (state == IDLE) && start;
    assign win_end_c = accept_c && (win_len_q != '0) && ((word_count + WIN_W'(1)) == win_len_q);
    assign diff_c    = (in_data_1 ^ in_data_2) | DATA_W'(err_inject);

    // Measurement controller; DRAIN waits out the popcount pipeline latency.
    always_ff @(posedge clk) begin
        if (rs) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
            win_len_q  <= '0;
            drain_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        word_count <= '0;
                        win_len_q  <= window_len;
                    end
                end
                RUN: begin
                    if (accept_c && (word_count != '1)) begin
                        word_count <= word_count + WIN_W'(1);
                    end
                    if (stop || win_end_c) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DCW'(D)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Level 0 holds the padded diff; level k holds PW>>k partial sums of k+1 bits.
    for (genvar k = 0; k <= LVL; k++) begin : g_lvl
        logic [(PW>>k)-1:0][k:0] sum;
        logic                    vld;

        if (k == 0) begin : g_s0
            always_ff @(posedge clk) begin
                if (rs) begin
                    sum <= '0;
                    vld <= 1'b0;
                end else begin
                    sum <= accept_c ? PW'(diff_c) : '0;
                    vld <= accept_c;
                end
            end
        end else begin : g_add
            logic [(PW>>k)-1:0][k:0] sum_c;

            for (genvar j = 0; j < (PW >> k); j++) begin : g_pair
                assign sum_c[j] = {1'b0, g_lvl[k-1].sum[2*j]} + {1'b0, g_lvl[k-1].sum[2*j+1]};
            end

            always_ff @(posedge clk) begin
                if (rs) begin
                    sum <= '0;
                    vld <= 1'b0;
                end else begin
                    sum <= sum_c;
                    vld <= g_lvl[k-1].vld;
                end
            end
        end
    end

    assign pop_c     = g_lvl[LVL].sum[0];
    assign pop_vld_c = g_lvl[LVL].vld;
    assign acc_sum_c = AW'(err_count) + AW'(pop_c);
    assign ovf_c     = acc_sum_c > AW'({CNT_W{1'b1}});

    // Saturating accumulator, cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (rs) begin
            err_count <= '0;
            saturated <= 1'b0;
        end else if (start_c) begin
            err_count <= '0;
            saturated <= 1'b0;
        end else if (pop_vld_c) begin
            if (ovf_c) begin
                err_count <= '1;
                saturated <= 1'b1;
            end else begin
                err_count <= CNT_W'(acc_sum_c);
            end
        end
    end

endmodule

// File: tb/tb_ber_window_counter.sv
// Bench for ber_window_counter: three instances (64/32, 10/8, 64/8) share
// stimulus and are checked against a window-level reference model.
module tb_ber_window_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rs, start, stop, in_valid, err_inject;
    logic [23:0] window_len;
    logic [63:0] d1, d2;

    logic [2:0]  busy_v, done_v, sat_v;
    logic [31:0] err_a;
    logic [7:0]  err_b, err_c;
    logic [23:0] wc_a, wc_c;
    logic [7:0]  wc_b;

    ber_window_counter u_a (
        .clk(clk), .rs(rs), .start(start), .stop(stop), .window_len(window_len),
        .in_valid(in_valid), .in_data_1(d1), .in_data_2(d2), .err_inject(err_inject),
        .busy(busy_v[0]), .done(done_v[0]), .err_count(err_a), .word_count(wc_a),
        .saturated(sat_v[0])
    );

    ber_window_counter #(.DATA_W(10), .CNT_W(8), .WIN_W(8)) u_b (
        .clk(clk), .rs(rs), .start(start), .stop(stop), .window_len(window_len[7:0]),
        .in_valid(in_valid), .in_data_1(d1[9:0]), .in_data_2(d2[9:0]), .err_inject(err_inject),
        .busy(busy_v[1]), .done(done_v[1]), .err_count(err_b), .word_count(wc_b),
        .saturated(sat_v[1])
    );

    ber_window_counter #(.DATA_W(64), .CNT_W(8), .WIN_W(24)) u_c (
        .clk(clk), .rs(rs), .start(start), .stop(stop), .window_len(window_len),
        .in_valid(in_valid), .in_data_1(d1), .in_data_2(d2), .err_inject(err_inject),
        .busy(busy_v[2]), .done(done_v[2]), .err_count(err_c), .word_count(wc_c),
        .saturated(sat_v[2])
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference state: expected totals per instance for the current window.
    longint unsigned exp_err [3];
    bit              exp_sat [3];
    int              exp_wc;
    int              dly  [3] = '{7, 5, 7};
    longint unsigned cmax [3] = '{64'hFFFF_FFFF, 64'd255, 64'd255};

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] get_err(input int i);
        case (i)
            0:       return 64'(err_a);
            1:       return 64'(err_b);
            default: return 64'(err_c);
        endcase
    endfunction

    function automatic logic [63:0] get_wc(input int i);
        case (i)
            0:       return 64'(wc_a);
            1:       return 64'(wc_b);
            default: return 64'(wc_c);
        endcase
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Reference: each accepted word adds its mismatch count, clipped at the counter maximum.
    task automatic model_add(input logic [63:0] diff);
        longint unsigned pop;
        for (int i = 0; i < 3; i++) begin
            pop = (i == 1) ? longint'($countones(diff[9:0])) : longint'($countones(diff));
            exp_err[i] = exp_err[i] + pop;
            if (exp_err[i] > cmax[i]) begin
                exp_err[i] = cmax[i];
                exp_sat[i] = 1'b1;
            end
        end
        exp_wc++;
    endtask

    task automatic gen(input int kind, input int w, output logic [63:0] a, output logic [63:0] b,
                       output logic inj);
        logic [63:0] masks [3];
        masks = '{64'h1, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF};
        a   = rnd64();
        inj = 1'b0;
        case (kind)
            1: begin a = '0; b = '1; end
            2: begin
                b   = (w == 4) ? (a ^ 64'h1) : a;
                inj = (w == 1) || (w == 4) || (w == 8);
            end
            3: b = a ^ 64'h21;
            4: b = a ^ masks[w % 3];
            default: begin b = rnd64(); inj = 1'($urandom % 2); end
        endcase
    endtask

    task automatic do_window(input int wlen, input int nwords, input int gap, input int kind,
                             input bit use_stop);
        logic [63:0] a, b;
        logic        inj;
        int          g;
        window_len = 24'(wlen);
        start      = 1'b1;
        tick();
        start = 1'b0;
        exp_wc = 0;
        for (int i = 0; i < 3; i++) begin
            exp_err[i] = 0;
            exp_sat[i] = 1'b0;
            chk($sformatf("start busy i%0d", i), 64'(busy_v[i]), 64'd1);
            chk($sformatf("start err i%0d", i), get_err(i), 64'd0);
            chk($sformatf("start wc i%0d", i), get_wc(i), 64'd0);
            chk($sformatf("start sat i%0d", i), 64'(sat_v[i]), 64'd0);
        end
        for (int w = 0; w < nwords; w++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            repeat (g) begin
                in_valid   = 1'b0;
                stop       = 1'b0;
                d1         = rnd64();
                d2         = rnd64();
                err_inject = 1'($urandom % 2);
                tick();
            end
            gen(kind, w, a, b, inj);
            d1         = a;
            d2         = b;
            err_inject = inj;
            in_valid   = 1'b1;
            stop       = use_stop && (w == nwords - 1);
            tick();
            model_add((a ^ b) | 64'(inj));
            chk($sformatf("run busy w%0d", w), 64'(busy_v[0]), 64'd1);
            for (int i = 0; i < 3; i++)
                chk($sformatf("run wc w%0d i%0d", w, i), get_wc(i), 64'(exp_wc));
        end
        // Post-window traffic, a stray start and stray stops must all be ignored.
        for (int t = 1; t <= 12; t++) begin
            in_valid   = 1'($urandom % 2);
            d1         = rnd64();
            d2         = rnd64();
            err_inject = 1'($urandom % 2);
            start      = (t == 2);
            stop       = 1'($urandom % 2);
            tick();
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("drain busy t%0d i%0d", t, i), 64'(busy_v[i]), 64'(t <= dly[i]));
                chk($sformatf("drain done t%0d i%0d", t, i), 64'(done_v[i]), 64'(t == dly[i] + 1));
                if (t >= dly[i] + 1) begin
                    chk($sformatf("final err t%0d i%0d", t, i), get_err(i), 64'(exp_err[i]));
                    chk($sformatf("final wc t%0d i%0d", t, i), get_wc(i), 64'(exp_wc));
                    chk($sformatf("final sat t%0d i%0d", t, i), 64'(sat_v[i]), 64'(exp_sat[i]));
                end
            end
        end
        start    = 1'b0;
        stop     = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s busy i%0d", tag, i), 64'(busy_v[i]), 64'd0);
            chk($sformatf("%s done i%0d", tag, i), 64'(done_v[i]), 64'd0);
            chk($sformatf("%s err i%0d", tag, i), get_err(i), 64'd0);
            chk($sformatf("%s wc i%0d", tag, i), get_wc(i), 64'd0);
            chk($sformatf("%s sat i%0d", tag, i), 64'(sat_v[i]), 64'd0);
        end
    endtask

    initial begin
        int wl, nw;
        bit us;
        rs = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0; err_inject = 1'b0;
        window_len = '0; d1 = '0; d2 = '0;
        repeat (3) tick();
        chk_zero("reset");
        rs = 1'b0;
        tick();

        do_window(4, 4, 0, 1, 1'b0);
        do_window(3, 3, 2, 4, 1'b0);
        do_window(5, 5, 0, 1, 1'b0);
        do_window(10, 10, -1, 2, 1'b0);
        do_window(0, 7, 0, 3, 1'b1);
        do_window(40, 40, 0, 1, 1'b0);
        for (int r = 0; r < 5; r++) begin
            wl = int'($urandom_range(1, 25));
            us = 1'($urandom % 2);
            nw = us ? int'($urandom_range(1, wl)) : wl;
            do_window(wl, nw, -1, 0, us);
        end
        do_window(0, 9, -1, 0, 1'b1);

        // Reset in the middle of a window: everything clears and no done appears.
        window_len = 24'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; d1 = '0; d2 = '1;
        repeat (2) tick();
        rs = 1'b1;
        tick();
        chk_zero("midrs");
        rs = 1'b0;
        for (int t = 0; t < 15; t++) begin
            d1 = rnd64();
            d2 = rnd64();
            tick();
            chk_zero($sformatf("postrs%0d", t));
        end
        in_valid = 1'b0;

        // Reset wins over a simultaneous start.
        rs = 1'b1;
        start = 1'b1;
        tick();
        rs = 1'b0;
        start = 1'b0;
        tick();
        chk_zero("rs_start");

        do_window(2, 2, 0, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ber_window_counter.md
# ber_window_counter

Parametrised bit-error counter for the analyser datapath. It compares a received word against a reference word, popcounts the mismatches through a registered adder tree, and accumulates the result into a saturating error counter over a programmable measurement window of words. It is the generalised successor of the fixed 64-bit error summator and sits between the pattern generator/receiver pair and the result readout logic, with start/stop control, valid qualification and error injection.

## Interface
- DATA_W, 64, compared word width; must be ≥2; non-power-of-two allowed.
- CNT_W, 32, error accumulator width.
- WIN_W, 24, width of the window length and word counter.

- clk  in  1  clock; all logic on rising edge.
- rs  in  1  reset; synchronous, active-high.
- start  in  1  begin measurement; honoured only in IDLE.
- stop  in  1  end measurement early; honoured only in RUN.
- window_len  in  WIN_W  words per window, latched at start; 0 = run until stop.
- in_valid  in  1  word pair valid this cycle.
- in_data_1  in  DATA_W  received word.
- in_data_2  in  DATA_W  reference word.
- err_inject  in  1  with an accepted word, force diff bit 0 to 1.
- busy  out  1  measurement in progress (RUN or DRAIN).
- done  out  1  one-cycle pulse when the final count is stable.
- err_count  out  CNT_W  accumulated bit errors.
- word_count  out  WIN_W  words accepted in the current/last window.
- saturated  out  1  sticky; err_count has clipped at all-ones.

## Operation
- FSM states: IDLE, RUN, DRAIN. Reset state is IDLE.
- IDLE → RUN on start. This clears err_count, word_count and saturated, and latches window_len.
- Word accepted when state = RUN and in_valid = 1. In IDLE and DRAIN, in_valid is ignored.
- Each accepted word does two things:
  - word_count += 1.
  - diff = in_data_1 ^ in_data_2, with diff[0] |= err_inject, enters the pipeline together with a valid bit.
- RUN → DRAIN when either:
  - an accepted word makes word_count == latched window_len (window_len ≠ 0), or
  - stop = 1. If stop coincides with an accepted word, that word is counted.
- DRAIN lasts D = clog2(DATA_W)+1 cycles. When it ends:
  - return to IDLE;
  - done = 1 for that one cycle;
  - busy = 0 from the same cycle.
- Popcount pipeline:
  - Stage 0 registers diff, zero-padded to the next power of two.
  - clog2(DATA_W) registered pairwise adder levels follow; level k output width is k+1 bits.
  - A valid bit travels alongside each stage. Bubbles contribute nothing.
- Accumulator:
  - On valid popcount, err_count <= min(err_count + pop, 2^CNT_W − 1).
  - saturated is set when the sum would exceed 2^CNT_W − 1. It stays set until the next start or rs.
- word_count wraps are impossible: a window ends at window_len. In continuous mode (window_len = 0), word_count saturates at all-ones.
- Results (err_count, word_count, saturated) hold in IDLE until the next start.
- start while busy is ignored. stop in IDLE or DRAIN is ignored.
- rs at any time:
  - clears FSM, pipeline registers, valid bits and all outputs to 0;
  - suppresses any pending done.
- rs wins over a simultaneous start.

## Timing
- Reset values: busy 0, done 0, err_count 0, word_count 0, saturated 0.
- start sampled at edge 0 → busy = 1 after edge 0. The first word can be accepted at edge 1.
- Word accepted at edge k:
  - word_count updates at edge k;
  - stage 0 at edge k, tree levels at edges k+1 … k+clog2(DATA_W);
  - err_count updates at edge k+clog2(DATA_W)+1.
- Last word accepted at edge N:
  - DRAIN occupies edges N+1 … N+D;
  - done and busy = 0 hold between edge N+D+1 and the following edge;
  - the final err_count is already valid when done rises.
- Example, DATA_W=64 and continuous valid: done follows edge N+8.
- Throughput: one word per cycle, no back-pressure.

## Test plan
- DATA_W=64, window_len=4, in_data_1=0, in_data_2=all-ones, in_valid constant → err_count=256, word_count=4, saturated=0, done after edge 12, busy low from the same cycle.
- window_len=3, words with 1, 0 and 63 differing bits, in_valid gaps of 2 cycles between words → err_count=64, word_count=3. Values presented while in_valid=0 are not counted.
- CNT_W=8, window_len=5, each word all bits differing (64 errors/word) → err_count=255, saturated=1. A following start clears both to 0.
- Identical data, window_len=10, err_inject on words 2, 5 and 9 → err_count=3. err_inject on a word whose bit 0 already differs adds 1 for that bit, not 2.
- window_len=0, 7 words of 2 errors each, stop asserted together with the 7th word → word_count=7, err_count=14, done after D+1 cycles. A second start during DRAIN is ignored.
- rs asserted at edge 3 of a window → all outputs 0, no done pulse. start and rs in the same cycle → stays IDLE.
- DATA_W=10, window_len=2, all bits differing → err_count=20.
